// File: rtl/key_pkg.sv
// Shared state encoding and default timing constants for the key press controller.
package key_pkg;

  localparam int unsigned LONG_TICKS_DEF = 16;
  localparam int unsigned RPT_TICKS_DEF  = 4;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned RPT_CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_e;

endpackage

// File: rtl/hold_timer.sv
// ce-gated tick counter; tc flags the tick that reaches limit and self-clears the count.
module hold_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  assign tc = ce && (cnt_q == (limit - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (ce) begin
      cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_press_ctrl.sv
// Classifies a debounced key into press / short / long / auto-repeat / release pulses.
module key_press_ctrl
  import key_pkg::*;
#(
  parameter int unsigned LONG_TICKS = LONG_TICKS_DEF,
  parameter int unsigned RPT_TICKS  = RPT_TICKS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 ce,
  input  logic                 key_up,
  input  logic                 key_en,
  output logic                 press,
  output logic                 short_press,
  output logic                 long_press,
  output logic                 rpt,
  // "release" is a reserved word, hence the past-tense name.
  output logic                 released,
  output logic [RPT_CNT_W-1:0] rpt_cnt,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(RPT_TICKS);

  key_state_e         state_q;
  logic               tick;
  logic               tmr_clr;
  logic               tc;
  logic [CNT_W-1:0]   limit;

  // Counter stays at zero while idle, so every accepted press starts from a fresh count.
  assign tick    = ce && key_en && (state_q != IDLE);
  assign tmr_clr = clr || (state_q == IDLE);
  assign limit   = (state_q == HELD) ? RPT_LIM : LONG_LIM;

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk  (clk),
    .clr  (tmr_clr),
    .ce   (tick),
    .limit(limit),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      rpt         <= 1'b0;
      released    <= 1'b0;
      rpt_cnt     <= '0;
      busy        <= 1'b0;
    end else begin
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      rpt         <= 1'b0;
      released    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_up) begin
            state_q <= PRESSED;
            rpt_cnt <= '0;
            press   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        PRESSED: begin
          // Release is checked first so it wins over a coinciding threshold.
          if (ce && !key_en) begin
            state_q     <= IDLE;
            short_press <= 1'b1;
            released    <= 1'b1;
            busy        <= 1'b0;
          end else if (tc) begin
            state_q    <= HELD;
            long_press <= 1'b1;
          end
        end
        HELD: begin
          if (ce && !key_en) begin
            state_q  <= IDLE;
            released <= 1'b1;
            busy     <= 1'b0;
          end else if (tc) begin
            rpt <= 1'b1;
            if (rpt_cnt != '1) begin
              rpt_cnt <= rpt_cnt + RPT_CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
